// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: run-level sequencer for the scan signal generator.
// Host writes land in a staging bank; a validated start commits them to the
// active bank, arms the generator, runs a number of frames and waits for the
// uplink to finish transmitting before reporting completion.
module scan_seq_ctrl #(
    parameter int RDY_TIMEOUT = 1000,
    parameter int TX_TIMEOUT  = 100000000
) (
    input  logic        sys_clk_100M,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        start,
    input  logic        abort,
    input  logic        err_clr,
    input  logic        frame_in,
    input  logic        idelay_rdy,
    input  logic        txdone,
    output logic        sig_reset,
    output logic [7:0]  frame_nums,
    output logic [7:0]  pixel_nums,
    output logic [7:0]  laser_nums,
    output logic [7:0]  spad_nums,
    output logic [8:0]  i_cnt_value,
    output logic [63:0] frame_period,
    output logic [31:0] pixel_period,
    output logic [31:0] laser_period,
    output logic [31:0] spad_period,
    output logic [31:0] sig_start_frame,
    output logic [31:0] sig_start_pixel,
    output logic [31:0] sig_start_laser,
    output logic [31:0] sig_start_spad,
    output logic [15:0] duty_cycle_frame,
    output logic [15:0] duty_cycle_pixel,
    output logic [15:0] duty_cycle_laser,
    output logic [15:0] duty_cycle_spad,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_ARM     = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    localparam logic [31:0] RDY_LAST = 32'(RDY_TIMEOUT - 1);
    localparam logic [31:0] TX_LAST  = 32'(TX_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [31:0] timer;

    logic [7:0]  stg_frame_nums, stg_pixel_nums, stg_laser_nums, stg_spad_nums;
    logic [8:0]  stg_i_cnt_value;
    logic [63:0] stg_frame_period;
    logic [31:0] stg_pixel_period, stg_laser_period, stg_spad_period;
    logic [31:0] stg_start_frame, stg_start_pixel, stg_start_laser, stg_start_spad;
    logic [15:0] stg_duty_frame, stg_duty_pixel, stg_duty_laser, stg_duty_spad;
    logic [15:0] stg_run_frames;
    logic [15:0] act_run_frames;

    logic        sync1, sync2, sync_prev, frame_rise;
    logic        cfg_ok;
    logic [15:0] frame_cnt_inc;

    assign busy      = (state == ST_CHECK) || (state == ST_ARM) ||
                       (state == ST_RUN)   || (state == ST_WAIT_TX);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign sig_reset = (state != ST_RUN);

    assign frame_cnt_inc = frame_cnt + 16'd1;

    // A staged configuration is runnable only with nonzero periods and each
    // duty strictly shorter than its period.
    assign cfg_ok = (stg_frame_period != 64'd0) && (stg_pixel_period != 32'd0) &&
                    (stg_laser_period != 32'd0) && (stg_spad_period != 32'd0) &&
                    ({48'd0, stg_duty_frame} < stg_frame_period) &&
                    ({16'd0, stg_duty_pixel} < stg_pixel_period) &&
                    ({16'd0, stg_duty_laser} < stg_laser_period) &&
                    ({16'd0, stg_duty_spad}  < stg_spad_period);

    // Host writes into the staging bank, accepted in every state.
    always_ff @(posedge sys_clk_100M) begin
        if (!reset) begin
            stg_frame_nums   <= '0;
            stg_pixel_nums   <= '0;
            stg_laser_nums   <= '0;
            stg_spad_nums    <= '0;
            stg_i_cnt_value  <= '0;
            stg_frame_period <= '0;
            stg_pixel_period <= '0;
            stg_laser_period <= '0;
            stg_spad_period  <= '0;
            stg_start_frame  <= '0;
            stg_start_pixel  <= '0;
            stg_start_laser  <= '0;
            stg_start_spad   <= '0;
            stg_duty_frame   <= '0;
            stg_duty_pixel   <= '0;
            stg_duty_laser   <= '0;
            stg_duty_spad    <= '0;
            stg_run_frames   <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                5'd0:  stg_frame_nums          <= wr_data[7:0];
                5'd1:  stg_pixel_nums          <= wr_data[7:0];
                5'd2:  stg_laser_nums          <= wr_data[7:0];
                5'd3:  stg_spad_nums           <= wr_data[7:0];
                5'd4:  stg_i_cnt_value         <= wr_data[8:0];
                5'd5:  stg_frame_period[31:0]  <= wr_data;
                5'd6:  stg_frame_period[63:32] <= wr_data;
                5'd7:  stg_pixel_period        <= wr_data;
                5'd8:  stg_laser_period        <= wr_data;
                5'd9:  stg_spad_period         <= wr_data;
                5'd10: stg_start_frame         <= wr_data;
                5'd11: stg_start_pixel         <= wr_data;
                5'd12: stg_start_laser         <= wr_data;
                5'd13: stg_start_spad          <= wr_data;
                5'd14: begin
                    stg_duty_frame <= wr_data[31:16];
                    stg_duty_pixel <= wr_data[15:0];
                end
                5'd15: begin
                    stg_duty_laser <= wr_data[31:16];
                    stg_duty_spad  <= wr_data[15:0];
                end
                5'd16: stg_run_frames <= wr_data[15:0];
                default: ;
            endcase
        end
    end

    // Bring the asynchronous frame output into this domain and mark rising edges.
    always_ff @(posedge sys_clk_100M) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            frame_rise <= 1'b0;
        end else begin
            sync1      <= frame_in;
            sync2      <= sync1;
            sync_prev  <= sync2;
            frame_rise <= sync2 & ~sync_prev;
        end
    end

    // Next-state selection; abort from any busy state overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_CHECK;
            ST_CHECK:   next_state = cfg_ok ? ST_ARM : ST_ERR;
            ST_ARM: begin
                if (idelay_rdy)             next_state = ST_RUN;
                else if (timer == RDY_LAST) next_state = ST_ERR;
            end
            ST_RUN: begin
                if (frame_rise && (act_run_frames != 16'd0) &&
                    (frame_cnt_inc == act_run_frames))
                    next_state = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (txdone)                next_state = ST_DONE;
                else if (timer == TX_LAST) next_state = ST_ERR;
            end
            ST_DONE:    next_state = ST_IDLE;
            ST_ERR:     if (err_clr) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (abort && busy) next_state = ST_IDLE;
    end

    // State register, timeout timer, error code and frame counter.
    always_ff @(posedge sys_clk_100M) begin
        if (!reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            err_code  <= 2'd0;
            frame_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                timer <= '0;
            else if ((state == ST_ARM) || (state == ST_WAIT_TX))
                timer <= timer + 32'd1;

            if ((next_state == ST_ERR) && (state != ST_ERR)) begin
                case (state)
                    ST_CHECK: err_code <= 2'd1;
                    ST_ARM:   err_code <= 2'd2;
                    default:  err_code <= 2'd3;
                endcase
            end else if ((state == ST_ERR) && (next_state == ST_IDLE)) begin
                err_code <= 2'd0;
            end

            if ((state == ST_IDLE) && (next_state == ST_CHECK))
                frame_cnt <= '0;
            else if ((state == ST_RUN) && frame_rise && !abort && (frame_cnt != 16'hFFFF))
                frame_cnt <= frame_cnt_inc;
        end
    end

    // Commit the validated staging bank to the active bank on leaving CHECK.
    always_ff @(posedge sys_clk_100M) begin
        if (!reset) begin
            frame_nums       <= '0;
            pixel_nums       <= '0;
            laser_nums       <= '0;
            spad_nums        <= '0;
            i_cnt_value      <= '0;
            frame_period     <= '0;
            pixel_period     <= '0;
            laser_period     <= '0;
            spad_period      <= '0;
            sig_start_frame  <= '0;
            sig_start_pixel  <= '0;
            sig_start_laser  <= '0;
            sig_start_spad   <= '0;
            duty_cycle_frame <= '0;
            duty_cycle_pixel <= '0;
            duty_cycle_laser <= '0;
            duty_cycle_spad  <= '0;
            act_run_frames   <= '0;
        end else if ((state == ST_CHECK) && (next_state == ST_ARM)) begin
            frame_nums       <= stg_frame_nums;
            pixel_nums       <= stg_pixel_nums;
            laser_nums       <= stg_laser_nums;
            spad_nums        <= stg_spad_nums;
            i_cnt_value      <= stg_i_cnt_value;
            frame_period     <= stg_frame_period;
            pixel_period     <= stg_pixel_period;
            laser_period     <= stg_laser_period;
            spad_period      <= stg_spad_period;
            sig_start_frame  <= stg_start_frame;
            sig_start_pixel  <= stg_start_pixel;
            sig_start_laser  <= stg_start_laser;
            sig_start_spad   <= stg_start_spad;
            duty_cycle_frame <= stg_duty_frame;
            duty_cycle_pixel <= stg_duty_pixel;
            duty_cycle_laser <= stg_duty_laser;
            duty_cycle_spad  <= stg_duty_spad;
            act_run_frames   <= stg_run_frames;
        end
    end

endmodule

// File: doc/scan_seq_ctrl.md
Name: scan_seq_ctrl

Overview:
- Run-level sequencer in front of the scan signal generator (frame/pixel/laser/spad pulse block).
- Takes host register writes into a staging bank, validates them on start and commits them to an active bank that drives the generator's configuration inputs.
- Holds the generator in reset while arming, waits for IDELAY ready, runs a programmed number of frames, then waits for the transmit-done handshake before reporting completion.

Parameters:
- RDY_TIMEOUT, 1000, cycles allowed in ARM for o_idelay_rdy before error.
- TX_TIMEOUT, 100000000, cycles allowed in WAIT_TX for txdone before error.

Ports:
- sys_clk_100M  input  1  sole clock.
- reset  input  1  synchronous, active-low reset.
- wr_en / wr_addr / wr_data  input  1 / 5 / 32  staging register write strobe, address, data.
- start / abort / err_clr  input  1 each  single-cycle control strobes.
- frame_in  input  1  frame output of generator; asynchronous to this logic.
- idelay_rdy  input  1  o_idelay_rdy from generator.
- txdone  input  1  transmit-complete level from uplink.
- sig_reset  output  1  reset to generator, active-high.
- frame_nums / pixel_nums / laser_nums / spad_nums  output  8 each  active-bank values.
- i_cnt_value  output  9  active bank.
- frame_period  output  64  active bank.
- pixel_period / laser_period / spad_period  output  32 each  active bank.
- sig_start_frame / sig_start_pixel / sig_start_laser / sig_start_spad  output  32 each  active bank.
- duty_cycle_frame / duty_cycle_pixel / duty_cycle_laser / duty_cycle_spad  output  16 each  active bank.
- busy / done / err  output  1 each  busy is a level, done is a 1-cycle pulse, err is sticky.
- err_code  output  2  1 = bad config, 2 = idelay timeout, 3 = txdone timeout.
- frame_cnt  output  16  frames completed in current run.

Behaviour:
- Reset (reset=0 at clock edge):
  - state IDLE; staging and active banks all zero.
  - sig_reset=1; busy=0, done=0, err=0, err_code=0, frame_cnt=0.
  - Synchronizers cleared.
- Staging map, by wr_addr:
  - 0-3: frame/pixel/laser/spad_nums [7:0].
  - 4: i_cnt_value [8:0].
  - 5: frame_period[31:0]; 6: frame_period[63:32].
  - 7-9: pixel/laser/spad_period.
  - 10-13: sig_start frame/pixel/laser/spad.
  - 14: duty_frame = data[31:16], duty_pixel = data[15:0].
  - 15: duty_laser = data[31:16], duty_spad = data[15:0].
  - 16: run_frames [15:0]; 0 means continuous.
  - 17-31: ignored.
  - Writes are accepted in every state and never touch the active bank.
- frame_in path: 2-flop synchronizer plus edge register. A rising edge is seen 3 cycles after the input transition.
- FSM:
  - IDLE: sig_reset=1, busy=0. start moves to CHECK; err must be 0, otherwise start is ignored.
  - CHECK (1 cycle): all four periods must be nonzero, and each duty must be strictly less than its period (duty zero-extended; frame compared against the 64-bit value). Fail: ERR with code 1. Pass: copy staging to active, go to ARM.
  - ARM: sig_reset=1, timer counts. When idelay_rdy=1 is sampled, go to RUN; sig_reset=0 from the next cycle. If timer reaches RDY_TIMEOUT: ERR with code 2.
  - RUN: each synchronized frame rising edge increments frame_cnt (saturates at 0xFFFF). When run_frames!=0 and frame_cnt reaches run_frames, go to WAIT_TX and set sig_reset=1.
  - WAIT_TX: the first cycle of txdone=1 after entry goes to DONE. A txdone level already high on entry counts. If timer reaches TX_TIMEOUT: ERR with code 3.
  - DONE (1 cycle): done=1, then IDLE. frame_cnt holds until the next start.
  - ERR: sig_reset=1, err=1 with err_code held. err_clr moves to IDLE and clears err and err_code.
- Counters and latency:
  - busy=1 in CHECK, ARM, RUN and WAIT_TX.
  - Start in cycle N: active bank valid from N+2.
  - frame_cnt clears on entry to CHECK.
  - The timer clears on every state change.
- abort in CHECK, ARM, RUN or WAIT_TX goes to IDLE next cycle with sig_reset=1 and no done pulse. abort wins over any simultaneous transition. abort in IDLE, DONE or ERR has no effect.
- Simultaneous events:
  - start in a non-IDLE state is ignored.
  - A frame edge in the same cycle as abort is not counted.
- Continuous mode (run_frames=0): stays in RUN until abort. frame_cnt saturates; it does not wrap.

Test Plan:
- Basic run: periods 100/50/10/5, duties 40/20/4/2, run_frames=3, idelay_rdy high 5 cycles after ARM, txdone pulse after 3 frames → active bank matches staging at N+2; frame_cnt=3; exactly one done pulse; sig_reset=0 only during RUN.
- Bad config: pixel_period=0 (then, separately, duty_laser=10 with laser_period=10), start → err=1, err_code=1, active bank unchanged. err_clr returns to IDLE.
- Idelay timeout: RDY_TIMEOUT=16, idelay_rdy held low → ERR with code 2 exactly 16 cycles after ARM entry; sig_reset stays 1 throughout.
- Abort mid-RUN at frame_cnt=1 of 5, then restart → IDLE with no done pulse; the new start clears frame_cnt to 0.
- Staging writes during RUN (pixel_period 100→200) → active pixel_period stays 100 until the next start.
- Reset asserted during WAIT_TX, and txdone already high on WAIT_TX entry → reset returns every output to its reset value; the pre-high txdone gives DONE one cycle after WAIT_TX entry.
